// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  // Host/loader side: drives fields and accepts encoded words.
  modport master (
    output in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

  // Encoder side.
  modport slave (
    input  in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/inst_encoder.sv
// RISC-V instruction encoder: packs decoded fields + immediate into a word,
// flags unrepresentable immediates, and streams words with sequential addresses.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  inst_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_word_t;

  enc_word_t       enc;
  enc_word_t       out_q;
  logic            out_vld_q;
  logic [AW-1:0]   idx_q;
  logic [7:0]      err_cnt_q;
  logic            in_hs;
  logic            out_hs;

  always_comb begin
    enc          = '0;
    enc.inst[6:0] = bus.opcode;
    unique case (bus.imm_sel)
      3'd0: begin
        enc.inst[31:7] = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd};
        enc.err        = bus.imm != {{20{bus.imm[11]}}, bus.imm[11:0]};
      end
      3'd1: begin
        enc.inst[31:7] = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0]};
        enc.err        = bus.imm != {{20{bus.imm[11]}}, bus.imm[11:0]};
      end
      3'd2: begin
        enc.inst[31:7] = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:1], bus.imm[11]};
        enc.err        = (bus.imm != {{19{bus.imm[12]}}, bus.imm[12:0]}) || bus.imm[0];
      end
      3'd3: begin
        enc.inst[31:7] = {bus.imm[31:12], bus.rd};
        enc.err        = |bus.imm[11:0];
      end
      3'd4: begin
        enc.inst[31:7] = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd};
        enc.err        = (bus.imm != {{11{bus.imm[20]}}, bus.imm[20:0]}) || bus.imm[0];
      end
      3'd5: begin
        enc.inst[31:7] = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd};
        enc.err        = |bus.imm[31:5];
      end
      3'd6: begin
        enc.inst[31:7] = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd};
        enc.err        = |bus.imm[31:12];
      end
      default: begin
        enc.inst[31:7] = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd};
        enc.err        = 1'b0;
      end
    endcase
  end

  // restart wins over both handshakes in its cycle
  assign bus.in_ready = !restart && (!out_vld_q || bus.out_ready);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = !restart && out_vld_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      idx_q     <= '0;
      err_cnt_q <= '0;
    end else if (restart) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      idx_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      if (in_hs) begin
        out_vld_q <= 1'b1;
        out_q     <= enc;
      end else if (out_hs) begin
        out_vld_q <= 1'b0;
      end
      // DEPTH is a power of two, so the index wraps on its own
      if (out_hs) begin
        idx_q <= idx_q + 1'b1;
        if (out_q.err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_inst  = out_q.inst;
  assign bus.out_err   = out_q.err;
  assign bus.out_addr  = BASE_ADDR + {30'(idx_q), 2'b00};
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder (DEPTH=4, BASE_ADDR=0x100).
module tb_inst_encoder;
  localparam logic [31:0] BASE = 32'h100;
  localparam int          DEP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  logic [31:0] exp_addr = BASE;
  int          exp_cnt = 0;
  bit          pend = 0;
  bit          pend_err = 0;

  inst_encoder_if bus ();

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a);
    return (a == BASE + 32'(4 * (DEP - 1))) ? BASE : a + 32'd4;
  endfunction

  // model of the edge at which the shown word (if any) is consumed
  task automatic consume();
    if (pend) begin
      exp_addr = nxt(exp_addr);
      if (pend_err && exp_cnt < 255) exp_cnt++;
      pend = 0;
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7);
    bus.imm_sel = sel; bus.imm = imm; bus.opcode = op; bus.rd = rd;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.funct3 = f3; bus.funct7 = f7;
  endtask

  task automatic send(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                      input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] exp_inst, input bit exp_err);
    drive(sel, imm, op, rd, rs1, rs2, f3, f7);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    consume();
    #1;
    bus.in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".inst"}, bus.out_inst, exp_inst);
    chk({tag, ".addr"}, bus.out_addr, exp_addr);
    chk({tag, ".err"}, 32'(bus.out_err), 32'(exp_err));
    chk({tag, ".cnt"}, 32'(bus.err_cnt), 32'(exp_cnt));
    pend = 1;
    pend_err = exp_err;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    consume();
    #1;
    chk("drain.valid", 32'(bus.out_valid), 32'd0);
    chk("drain.cnt", 32'(bus.err_cnt), 32'(exp_cnt));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);

    // reset state
    #12;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.inst", bus.out_inst, 32'd0);
    chk("rst.err", 32'(bus.out_err), 32'd0);
    chk("rst.addr", bus.out_addr, BASE);
    chk("rst.cnt", 32'(bus.err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // encodes; five words also walk the address through its wrap
    send("addi", 3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFF1_0093, 0);
    send("sw",   3'd1, 32'd8,         7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h0051_2423, 0);
    send("beq",  3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFE00_0EE3, 0);
    send("lui",  3'd3, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_52B7, 0);
    send("jal",  3'd4, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_00EF, 0);
    send("slli", 3'd5, 32'd5,         7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0, 32'h0052_1193, 0);
    send("csr",  3'd6, 32'h300,       7'h73, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'h3001_10F3, 0);
    send("add",  3'd7, 32'hDEAD_BEEF, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0031_00B3, 0);

    // range errors
    send("b_odd",  3'd2, 32'd3,          7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0163, 1);
    send("u_low",  3'd3, 32'h1234_5001,  7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5037, 1);
    chk("cnt_after_b", 32'(bus.err_cnt), 32'd1);
    send("i_2048", 3'd0, 32'd2048,       7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8000_0013, 1);
    chk("cnt_after_u", 32'(bus.err_cnt), 32'd2);
    send("sh_32",  3'd5, 32'd32,         7'h13, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0, 32'h0000_1013, 1);
    drain();
    chk("cnt_4", 32'(bus.err_cnt), 32'd4);

    // saturation
    for (int i = 0; i < 300; i++)
      send("sat", 3'd3, 32'd1, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0037, 1);
    drain();
    chk("cnt_sat", 32'(bus.err_cnt), 32'd255);

    // backpressure: 3-cycle stall with a second bundle waiting
    send("bp_a", 3'd0, 32'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0070_0093, 0);
    drive(3'd0, 32'd9, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    chk("bp.in_ready0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp.inst", bus.out_inst, 32'h0070_0093);
      chk("bp.addr", bus.out_addr, exp_addr);
    end
    send("bp_b", 3'd0, 32'd9,  7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0090_0113, 0);
    send("bp_c", 3'd0, 32'd10, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00A0_0193, 0);
    drain();

    // restart while stalled, with out_ready and a bundle raised in the same cycle
    send("rs_a", 3'd3, 32'd1, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0037, 1);
    bus.out_ready = 1'b0;
    restart = 1'b1;
    #1;
    bus.out_ready = 1'b1;
    drive(3'd0, 32'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0);
    bus.in_valid = 1'b1;
    #1;
    chk("rs.in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    pend = 0; exp_addr = BASE; exp_cnt = 0;
    #1;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    chk("rs.valid", 32'(bus.out_valid), 32'd0);
    chk("rs.addr", bus.out_addr, BASE);
    chk("rs.cnt", 32'(bus.err_cnt), 32'd0);
    send("rs_b", 3'd0, 32'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0213, 0);
    send("rs_c", 3'd0, 32'd2, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0020_0293, 0);

    // async reset mid-stream, between edges
    send("ar_a", 3'd3, 32'd1, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0037, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(bus.out_valid), 32'd0);
    chk("ar.inst", bus.out_inst, 32'd0);
    chk("ar.err", 32'(bus.out_err), 32'd0);
    chk("ar.addr", bus.out_addr, BASE);
    chk("ar.cnt", 32'(bus.err_cnt), 32'd0);
    pend = 0; exp_addr = BASE; exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("ar_b", 3'd0, 32'd3, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0030_0313, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V instruction encoder: the inverse of the immediate extender. Accepts decoded fields plus a full 32-bit immediate and an immediate-format select, packs them into a 32-bit instruction word, range-checks the immediate, and emits the word with a sequential instruction-memory write address. It sits between the host/program loader and the core's instruction memory, so GEMM kernels can be generated and loaded at run time.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first emitted word.
- `DEPTH`, 1024: words in the target memory; the address wraps after DEPTH words. Power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `restart`  in  1  synchronous clear of address, error count and output register.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  bundle accepted when `in_valid && in_ready`.
- `imm_sel`  in  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 I-shamt, 6 CSR, 7 R (no immediate).
- `opcode`  in  7; `rd`, `rs1`, `rs2`  in  5 each; `funct3`  in  3; `funct7`  in  7.
- `imm`  in  32  immediate, in the same form the extender produces.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  32  byte address for `out_inst`.
- `out_err`  out  1  the immediate of this word was not representable.
- `err_cnt`  out  8  saturating count of emitted words with `out_err=1`.

## Operation
- Field placement: `opcode`→[6:0] always.
- I: imm[11:0]→[31:20], rs1, funct3, rd.
- S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
- B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7.
- U: imm[31:12]→[31:12], rd. J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd.
- I-shamt: funct7→[31:25], imm[4:0]→[24:20], rs1, funct3, rd.
- CSR: imm[11:0]→[31:20], rs1 (zimm/source), funct3, rd.
- R: funct7, rs2, rs1, funct3, rd; imm ignored.
- Range errors:
  - I and S: imm ≠ sign-extension of imm[11:0].
  - B: imm ≠ sext(imm[12:0]) or imm[0]=1.
  - J: imm ≠ sext(imm[20:0]) or imm[0]=1.
  - U: imm[11:0] ≠ 0.
  - I-shamt: imm > 31 unsigned. CSR: imm > 4095 unsigned. R: never.
- On an error the word is still emitted, with truncated bits as placed above and `out_err=1`.
- One-entry output register: `in_ready = !out_valid || out_ready`. Full throughput: one word per cycle under continuous ready.
- Address counter: starts at BASE_ADDR and advances by 4 on each output handshake. After BASE_ADDR+4·(DEPTH−1) it returns to BASE_ADDR.
- `err_cnt` increments on each output handshake with `out_err=1` and saturates at 255.
- `restart` has priority over all handshakes in its cycle:
  - clears `out_valid` (a pending word is dropped);
  - resets the address to BASE_ADDR and `err_cnt` to 0;
  - forces `in_ready=0` in that cycle.

## Timing
- Reset values: `out_valid=0`, `out_inst=0`, `out_err=0`, `out_addr=BASE_ADDR`, `err_cnt=0`. After reset, `in_ready=1`.
- Latency: a bundle accepted at edge N appears on `out_*` after edge N, i.e. in cycle N+1.
- Output stability: `out_inst`, `out_addr` and `out_err` are held stable while `out_valid && !out_ready`.
- Simultaneous output and input handshake in the same cycle: the register reloads with the new word, and `out_addr` advances by 4.
- Reset asserted mid-stream: all state returns to reset values immediately; a pending word is lost.

## Test plan
- Encode cases, `out_ready=1`, `out_err=0` on each:
  - addi x1,x2,−1 (sel 0, imm 32'hFFFF_FFFF, rs1 2, rd 1, funct3 0, opcode 7'h13) → `out_inst=32'hFFF1_0093`, `out_addr=BASE_ADDR`.
  - sw x5,8(x2) (sel 1, imm 8, rs2 5, rs1 2, funct3 2, opcode 7'h23) → 32'h0051_2423.
  - beq x0,x0,−4 (sel 2, imm 32'hFFFF_FFFC, opcode 7'h63) → 32'hFE00_0EE3.
  - lui x5,0x12345 (sel 3, imm 32'h1234_5000, opcode 7'h37) → 32'h1234_52B7.
- Range errors:
  - sel 2 with imm 3 → `out_err=1`, `err_cnt=1`.
  - sel 3 with imm 32'h1234_5001 → `out_err=1`, `err_cnt=2`.
  - sel 0 with imm 2048 → `out_err=1`.
  - Drive 300 erroring words → `err_cnt` holds at 255.
- Backpressure: 3-cycle stall with `out_ready=0` and `in_valid=1` held.
  - `in_ready=0` and `out_inst` stable throughout the stall.
  - After release, words emerge in order with no loss or duplication.
- Address wrap: DEPTH=4, BASE_ADDR=32'h100, 5 words → `out_addr` = 100, 104, 108, 10C, 100.
- Restart and reset:
  - Pulse `restart` while `out_valid=1` and stalled → pending word dropped; next word emitted at BASE_ADDR with `err_cnt=0`.
  - Async `rst_n` low mid-stream → reset values immediately.
